// File: rtl/full_adder_pkg.sv
// Shared constants and the golden-value helper for the full_adder family.
// fa_ref zero-extends its operands, so bit WIDTH of the result is the carry for any WIDTH up to FA_REF_MAX_WIDTH.
package full_adder_pkg;

  localparam int FA_WIDTH_DEFAULT = 1;
  localparam int FA_REF_MAX_WIDTH = 64;

  typedef logic [FA_REF_MAX_WIDTH-1:0] fa_operand_t;
  typedef logic [FA_REF_MAX_WIDTH:0]   fa_result_t;

  function automatic fa_result_t fa_ref(input fa_operand_t a, input fa_operand_t b, input logic cin);
    fa_result_t res;
    res = {1'b0, a} + {1'b0, b} + fa_result_t'(cin);
    return res;
  endfunction

endpackage

// File: rtl/full_adder_fa_bit.sv
// Single-bit full-adder slice: sum is the parity of the three inputs, carry is their majority.
module fa_bit (
  input  logic a_in,
  input  logic b_in,
  input  logic c_in,
  output logic sum_out,
  output logic carry_out
);

  assign sum_out   = a_in ^ b_in ^ c_in;
  assign carry_out = (a_in & b_in) | (a_in & c_in) | (b_in & c_in);

endmodule

// File: rtl/full_adder.sv
// WIDTH-bit ripple-carry adder built from fa_bit slices.
// Define FULL_ADDER_OUTREG_EN to register sum/carry on clk_in with asynchronous active-high rst_in.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int WIDTH = FA_WIDTH_DEFAULT
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out
);

  // carry_chain[i] feeds slice i; the last entry is the adder's carry-out.
  logic [WIDTH:0]   carry_chain;
  logic [WIDTH-1:0] sum_comb;

  assign carry_chain[0] = c_in;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_slice
      fa_bit u_fa_bit (
        .a_in      (a_in[gi]),
        .b_in      (b_in[gi]),
        .c_in      (carry_chain[gi]),
        .sum_out   (sum_comb[gi]),
        .carry_out (carry_chain[gi+1])
      );
    end
  endgenerate

`ifdef FULL_ADDER_OUTREG_EN
  logic [WIDTH-1:0] sum_d, sum_q;
  logic             carry_d, carry_q;

  always_comb begin
    sum_d   = sum_comb;
    carry_d = carry_chain[WIDTH];
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

  assign sum_out   = sum_q;
  assign carry_out = carry_q;
`else
  // Clock and reset are deliberately unused in the purely combinational build.
  logic unused_clk_rst;
  assign unused_clk_rst = clk_in ^ rst_in;

  assign sum_out   = sum_comb;
  assign carry_out = carry_chain[WIDTH];
`endif

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder at WIDTH 1, 4 and 8; follows FULL_ADDER_OUTREG_EN if defined.
module tb_full_adder;
  import full_adder_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       a1, b1, c1, s1, co1;
  logic [3:0] a4, b4, s4;
  logic       c4, co4;
  logic [7:0] a8, b8, s8;
  logic       c8, co8;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  full_adder #(.WIDTH(1)) u_dut1 (
    .clk_in(clk), .rst_in(rst), .a_in(a1), .b_in(b1), .c_in(c1), .sum_out(s1), .carry_out(co1)
  );
  full_adder #(.WIDTH(4)) u_dut4 (
    .clk_in(clk), .rst_in(rst), .a_in(a4), .b_in(b4), .c_in(c4), .sum_out(s4), .carry_out(co4)
  );
  full_adder #(.WIDTH(8)) u_dut8 (
    .clk_in(clk), .rst_in(rst), .a_in(a8), .b_in(b8), .c_in(c8), .sum_out(s8), .carry_out(co8)
  );

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs are driven just after a falling edge; results are sampled 1 ns after they are valid.
  task automatic settle();
`ifdef FULL_ADDER_OUTREG_EN
    @(posedge clk);
    #1;
`else
    #1;
`endif
  endtask

  task automatic dir8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic c,
                      input logic [7:0] exp_sum, input logic exp_carry);
    @(negedge clk);
    a8 = a; b8 = b; c8 = c;
    settle();
    chk(tag, {co8, s8}, {exp_carry, exp_sum});
    $display("w8 %s a=%h b=%h cin=%b -> sum=%h carry=%b", tag, a, b, c, s8, co8);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] tt [8];
    logic [8:0] exp9;
    logic [4:0] exp5;
    logic [2:0] v3;
    logic [8:0] v9;
    fa_result_t ref_r;

    // Truth table as {sum, carry}, indexed by {a, b, cin}.
    tt = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};

    a1 = 0; b1 = 0; c1 = 0;
    a4 = 0; b4 = 0; c4 = 0;
    a8 = 0; b8 = 0; c8 = 0;

    // Reset with all-ones inputs on the 1-bit adder.
    #1;
    rst = 1'b1;
    a1 = 1; b1 = 1; c1 = 1;
    @(negedge clk);
    settle();
`ifdef FULL_ADDER_OUTREG_EN
    chk("reset_hold", 9'({co1, s1}), 9'h0);
`else
    chk("reset_ignored", 9'({co1, s1}), 9'b11);
`endif
    $display("reset rst=1 abc=111 -> sum=%b carry=%b", s1, co1);

`ifdef FULL_ADDER_OUTREG_EN
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("first_capture", 9'({co1, s1}), 9'b11);
    $display("release first edge -> sum=%b carry=%b", s1, co1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset", 9'({co1, s1}), 9'h0);
    $display("mid-cycle reset -> sum=%b carry=%b", s1, co1);
    @(negedge clk);
    rst = 1'b0;
    a1 = 0; b1 = 0; c1 = 1;
    @(posedge clk);
    #1;
    chk("capture_001", 9'({co1, s1}), 9'b01);
    #2;
    b1 = 1;
    #1;
    chk("midcycle_hold", 9'({co1, s1}), 9'b01);
    @(posedge clk);
    #1;
    chk("capture_011", 9'({co1, s1}), 9'b10);
    $display("mid-cycle 001->011 -> sum=%b carry=%b", s1, co1);
`else
    @(negedge clk);
    rst = 1'b0;
`endif

    // WIDTH=1 truth-table sweep.
    $monitor("w1 t=%0t abc=%b%b%b -> sum=%b carry=%b", $time, a1, b1, c1, s1, co1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      v3 = 3'(i);
      {a1, b1, c1} = v3;
      settle();
      chk($sformatf("tt_%0d", i), 9'({s1, co1}), 9'(tt[i]));
    end
    #1;
    $monitoroff;

    // WIDTH=8 directed boundary and ripple cases.
    dir8("max_plus_cin", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1);
    dir8("all_ones",     8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    dir8("no_ripple",    8'h5A, 8'hA5, 1'b0, 8'hFF, 1'b0);
    dir8("full_ripple",  8'h5A, 8'hA5, 1'b1, 8'h00, 1'b1);
    dir8("all_zeros",    8'h00, 8'h00, 1'b0, 8'h00, 1'b0);

    // WIDTH=8 random vectors against plain arithmetic.
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      c8 = 1'($urandom);
      exp9 = {1'b0, a8} + {1'b0, b8} + 9'(c8);
      settle();
      chk($sformatf("w8_rand_%0d", i), {co8, s8}, exp9);
      $display("w8 rand %0d a=%h b=%h cin=%b -> %h exp %h", i, a8, b8, c8, {co8, s8}, exp9);
    end

    // WIDTH=4 exhaustive against arithmetic and against fa_ref.
    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      v9 = 9'(i);
      {a4, b4, c4} = v9;
      exp5 = {1'b0, a4} + {1'b0, b4} + 5'(c4);
      settle();
      chk($sformatf("w4_arith_%0d", i), 9'({co4, s4}), 9'(exp5));
      ref_r = fa_ref(fa_operand_t'(a4), fa_operand_t'(b4), c4);
      chk($sformatf("w4_faref_%0d", i), 9'({co4, s4}), 9'(ref_r[4:0]));
      $display("w4 a=%h b=%h cin=%b -> %h", a4, b4, c4, {co4, s4});
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/full_adder.md
Name: full_adder

Overview:
- Parameterizable ripple-carry adder built from single-bit full-adder slices; default WIDTH=1 is the classic 1-bit full adder (sum = a^b^cin, carry = majority).
- Leaf arithmetic block for datapaths and the reference cell for adder-based units.
- Combinational by default. An optional output register stage is provided, clocked by the single clock with asynchronous active-high reset.

Parameters:
- WIDTH, 1, operand width in bits (>=1).

Ports:
- clk_in  input  1  clock; used only when the output register is compiled in.
- rst_in  input  1  reset, asynchronous, active-high; used only when the output register is compiled in.
- a_in  input  WIDTH  operand A, unsigned.
- b_in  input  WIDTH  operand B, unsigned.
- c_in  input  1  carry-in.
- sum_out  output  WIDTH  sum bits.
- carry_out  output  1  carry-out of the MSB slice.

Behaviour:
- Arithmetic:
  - {carry_out, sum_out} = a_in + b_in + c_in, computed at WIDTH+1 bits; no truncation of the carry.
- Per-slice equations:
  - s[i] = a[i] ^ b[i] ^ c[i]
  - c[i+1] = (a[i]&b[i]) | (a[i]&c[i]) | (b[i]&c[i])
  - c[0] = c_in; carry_out = c[WIDTH].
- Default build, no macro:
  - Purely combinational, zero latency.
  - Outputs settle within the same delta/time step as any input change.
  - clk_in and rst_in are ignored.
  - No X on outputs when all inputs are known.
- Boundary cases:
  - All-ones + all-ones + 1 -> sum all-ones, carry 1.
  - All-zeros + all-zeros + 0 -> sum 0, carry 0.
  - Max + 0 + 1 wraps sum to 0 with carry 1.
- WIDTH=1 truth table, listed as {a,b,cin} -> {sum,carry}:
  - 000->00, 001->10, 010->10, 011->01
  - 100->10, 101->01, 110->01, 111->11
- No internal state in the default build, so reset has no effect.

Optional Feature:
- Macro: FULL_ADDER_OUTREG_EN.
- Defined:
  - sum_out and carry_out are registered on the rising edge of clk_in; latency 1 cycle.
  - rst_in high asynchronously forces sum_out=0 and carry_out=0, regardless of clock.
  - Registers hold 0 while rst_in is high. The first capture occurs on the first rising edge after rst_in deasserts.
  - Inputs changing mid-cycle do not affect outputs until the next edge.
- Undefined: combinational behaviour as above; no flops are inferred.

Decomposition:
- Shared package full_adder_pkg:
  - FA_WIDTH_DEFAULT = 1.
  - Function fa_ref(a, b, cin), returning the {carry, sum} golden value, for verification.
- Sub-module fa_bit: 1-bit combinational slice, ports a_in, b_in, c_in, sum_out, carry_out.
  - Instantiated WIDTH times in a generate loop chaining carries.
- Top full_adder holds the generate chain plus the optional register stage.

Test Plan:
- WIDTH=1 combinational; sweep {a,b,cin}=0..7, one value per 10 ns -> sum/carry match the truth table: 0:00, 1:10, 2:10, 3:01, 4:10, 5:01, 6:01, 7:11. $monitor logs each change.
- WIDTH=8; a=8'hFF, b=8'h00, cin=1 -> sum=8'h00, carry=1. Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, carry=1.
- WIDTH=8; a=8'h5A, b=8'hA5, cin=0 -> sum=8'hFF, carry=0 (no ripple). Then cin=1 -> sum=8'h00, carry=1 (full-length ripple).
- WIDTH=4; exhaustive 512 combinations checked against fa_ref -> zero mismatches.
- FULL_ADDER_OUTREG_EN, WIDTH=1:
  - Hold rst_in=1 with inputs 3'b111 -> outputs 0.
  - Release rst_in; first rising edge -> sum=1, carry=1.
  - Assert rst_in between edges -> outputs go to 0 immediately.
- FULL_ADDER_OUTREG_EN; change inputs from 3'b001 to 3'b011 mid-cycle -> outputs stay {sum=1,carry=0} until the next edge, then become {0,1}.
